// File: rtl/bg_controller.sv
// Frame-level sequencer for an array of background-removal PEs: runs the sum phase,
// averages the per-PE channel sums into an expected background colour, then runs bg removal.
module bg_controller #(
    parameter int LOG2_PE = 2,
    localparam int NUM_PE = 2 ** LOG2_PE
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Ack,
    input  logic [7:0]            threshold_in,
    input  logic [7:0]            desired_bg_r_in,
    input  logic [7:0]            desired_bg_g_in,
    input  logic [7:0]            desired_bg_b_in,
    input  logic [8*NUM_PE-1:0]   red_sum_bus,
    input  logic [8*NUM_PE-1:0]   green_sum_bus,
    input  logic [8*NUM_PE-1:0]   blue_sum_bus,
    input  logic [NUM_PE-1:0]     pe_Qsd,
    input  logic [NUM_PE-1:0]     pe_Qbgd,
    output logic                  Start_Sum,
    output logic                  Start_BgRemoval,
    output logic                  pe_Ack,
    output logic [7:0]            red_exp,
    output logic [7:0]            green_exp,
    output logic [7:0]            blue_exp,
    output logic [7:0]            threshold,
    output logic [7:0]            desired_bg_r,
    output logic [7:0]            desired_bg_g,
    output logic [7:0]            desired_bg_b,
    output logic                  Qi,
    output logic                  Qsum,
    output logic                  Qacc,
    output logic                  Qbgr,
    output logic                  Qbgw,
    output logic                  Qdone,
    output logic                  Done
);

    localparam int IW = (LOG2_PE > 0) ? LOG2_PE : 1;
    localparam int AW = 8 + LOG2_PE;

    // One-hot encoding so the state register bits drive the Q* flags directly.
    typedef enum logic [5:0] {
        INIT = 6'b000001,
        SUM  = 6'b000010,
        ACC  = 6'b000100,
        BGR  = 6'b001000,
        BGW  = 6'b010000,
        DONE = 6'b100000
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [AW-1:0]   red_acc, green_acc, blue_acc;
    logic [7:0]      red_byte, green_byte, blue_byte;
    logic [AW-1:0]   red_total, green_total, blue_total;
    logic [AW-1:0]   red_avg, green_avg, blue_avg;

    assign Qi    = state[0];
    assign Qsum  = state[1];
    assign Qacc  = state[2];
    assign Qbgr  = state[3];
    assign Qbgw  = state[4];
    assign Qdone = state[5];
    assign Done  = state[5];

    always_comb begin
        red_byte    = red_sum_bus[{idx, 3'b000} +: 8];
        green_byte  = green_sum_bus[{idx, 3'b000} +: 8];
        blue_byte   = blue_sum_bus[{idx, 3'b000} +: 8];
        red_total   = red_acc + AW'(red_byte);
        green_total = green_acc + AW'(green_byte);
        blue_total  = blue_acc + AW'(blue_byte);
        red_avg     = red_total >> LOG2_PE;
        green_avg   = green_total >> LOG2_PE;
        blue_avg    = blue_total >> LOG2_PE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= INIT;
            idx             <= '0;
            red_acc         <= '0;
            green_acc       <= '0;
            blue_acc        <= '0;
            red_exp         <= '0;
            green_exp       <= '0;
            blue_exp        <= '0;
            threshold       <= '0;
            desired_bg_r    <= '0;
            desired_bg_g    <= '0;
            desired_bg_b    <= '0;
            Start_Sum       <= 1'b0;
            Start_BgRemoval <= 1'b0;
            pe_Ack          <= 1'b0;
        end else begin
            Start_Sum       <= 1'b0;
            Start_BgRemoval <= 1'b0;
            pe_Ack          <= 1'b0;
            case (state)
                INIT: begin
                    if (Start) begin
                        threshold    <= threshold_in;
                        desired_bg_r <= desired_bg_r_in;
                        desired_bg_g <= desired_bg_g_in;
                        desired_bg_b <= desired_bg_b_in;
                        Start_Sum    <= 1'b1;
                        state        <= SUM;
                    end
                end
                SUM: begin
                    if (&pe_Qsd) begin
                        red_acc   <= '0;
                        green_acc <= '0;
                        blue_acc  <= '0;
                        idx       <= '0;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    red_acc   <= red_total;
                    green_acc <= green_total;
                    blue_acc  <= blue_total;
                    idx       <= idx + IW'(1);
                    if (idx == IW'(NUM_PE - 1)) begin
                        red_exp   <= red_avg[7:0];
                        green_exp <= green_avg[7:0];
                        blue_exp  <= blue_avg[7:0];
                        pe_Ack    <= 1'b1;
                        state     <= BGR;
                    end
                end
                BGR: begin
                    Start_BgRemoval <= 1'b1;
                    state           <= BGW;
                end
                BGW: begin
                    // Start_BgRemoval is high only in the first BGW cycle; stale done flags are ignored there.
                    if ((&pe_Qbgd) && !Start_BgRemoval) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (Ack) begin
                        pe_Ack <= 1'b1;
                        state  <= INIT;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_controller.sv
// Directed self-checking bench for bg_controller with four PEs; PE flags and sums
// are driven by hand from each scenario task.
module tb_bg_controller;

    localparam int LOG2_PE = 2;
    localparam int NUM_PE  = 4;
    localparam logic [5:0] ST_INIT = 6'b100000;
    localparam logic [5:0] ST_SUM  = 6'b010000;
    localparam logic [5:0] ST_ACC  = 6'b001000;
    localparam logic [5:0] ST_BGR  = 6'b000100;
    localparam logic [5:0] ST_BGW  = 6'b000010;
    localparam logic [5:0] ST_DONE = 6'b000001;

    logic clk = 1'b0;
    logic reset, start, ack;
    logic [7:0] threshold_in, desired_bg_r_in, desired_bg_g_in, desired_bg_b_in;
    logic [8*NUM_PE-1:0] red_sum_bus, green_sum_bus, blue_sum_bus;
    logic [NUM_PE-1:0] pe_qsd, pe_qbgd;
    logic start_sum, start_bgremoval, pe_ack;
    logic [7:0] red_exp, green_exp, blue_exp;
    logic [7:0] threshold, desired_bg_r, desired_bg_g, desired_bg_b;
    logic qi, qsum, qacc, qbgr, qbgw, qdone, done;
    logic [5:0] st;

    int n_checks = 0;
    int n_fail = 0;

    assign st = {qi, qsum, qacc, qbgr, qbgw, qdone};

    bg_controller #(.LOG2_PE(LOG2_PE)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Ack(ack),
        .threshold_in(threshold_in), .desired_bg_r_in(desired_bg_r_in),
        .desired_bg_g_in(desired_bg_g_in), .desired_bg_b_in(desired_bg_b_in),
        .red_sum_bus(red_sum_bus), .green_sum_bus(green_sum_bus), .blue_sum_bus(blue_sum_bus),
        .pe_Qsd(pe_qsd), .pe_Qbgd(pe_qbgd),
        .Start_Sum(start_sum), .Start_BgRemoval(start_bgremoval), .pe_Ack(pe_ack),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
        .threshold(threshold), .desired_bg_r(desired_bg_r),
        .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b),
        .Qi(qi), .Qsum(qsum), .Qacc(qacc), .Qbgr(qbgr), .Qbgw(qbgw), .Qdone(qdone),
        .Done(done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom_range(0, 1));
            ack = 1'($urandom_range(0, 1));
            threshold_in = 8'($urandom_range(0, 255));
            desired_bg_r_in = 8'($urandom_range(0, 255));
            pe_qsd = 4'($urandom_range(0, 15));
            pe_qbgd = 4'($urandom_range(0, 15));
            red_sum_bus = 32'($urandom);
            step(1);
            n_checks++;
            if (st !== ST_INIT) begin
                $display("FAIL reset_state: got %b expected %b", st, ST_INIT); n_fail++;
            end
            n_checks++;
            if ({start_sum, start_bgremoval, pe_ack, done} !== 4'b0000) begin
                $display("FAIL reset_pulses: got %b expected 0000", {start_sum, start_bgremoval, pe_ack, done}); n_fail++;
            end
            n_checks++;
            if ({red_exp, green_exp, blue_exp, threshold, desired_bg_r, desired_bg_g, desired_bg_b} !== 56'h0) begin
                $display("FAIL reset_regs: got %h expected 0", {red_exp, green_exp, blue_exp, threshold, desired_bg_r, desired_bg_g, desired_bg_b}); n_fail++;
            end
        end
        start = 1'b0; ack = 1'b0; pe_qsd = '0; pe_qbgd = '0;
        red_sum_bus = '0; green_sum_bus = '0; blue_sum_bus = '0;
        reset = 1'b0;
        threshold_in = 8'd30; desired_bg_r_in = 8'd10; desired_bg_g_in = 8'd10; desired_bg_b_in = 8'd10;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_checks++;
        if ({st, start_sum} !== {ST_SUM, 1'b1}) begin
            $display("FAIL start_accept: got state %b start_sum %b expected %b 1", st, start_sum, ST_SUM); n_fail++;
        end
        n_checks++;
        if ({threshold, desired_bg_r, desired_bg_g, desired_bg_b} !== {8'd30, 8'd10, 8'd10, 8'd10}) begin
            $display("FAIL start_config: got %h expected 1e0a0a0a", {threshold, desired_bg_r, desired_bg_g, desired_bg_b}); n_fail++;
        end
        for (int i = 0; i < 2; i++) begin
            step(1);
            n_checks++;
            if ({st, start_sum} !== {ST_SUM, 1'b0}) begin
                $display("FAIL start_sum_single: got state %b start_sum %b expected %b 0", st, start_sum, ST_SUM); n_fail++;
            end
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_checks++;
        if ({st, threshold, desired_bg_r} !== {ST_INIT, 16'h0}) begin
            $display("FAIL reset_from_sum: got %b/%h expected %b/0000", st, {threshold, desired_bg_r}, ST_INIT); n_fail++;
        end
    endtask

    task automatic do_frame(input logic [7:0] thr, input logic [7:0] br, input logic [7:0] bgc, input logic [7:0] bb,
                            input logic [31:0] rbus, input logic [31:0] gbus, input logic [31:0] bbus,
                            input logic [23:0] exp_rgb, input logic [23:0] prev_rgb);
        threshold_in = thr; desired_bg_r_in = br; desired_bg_g_in = bgc; desired_bg_b_in = bb;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_checks++;
        if ({st, start_sum} !== {ST_SUM, 1'b1}) begin
            $display("FAIL frame_start: got %b/%b expected %b/1", st, start_sum, ST_SUM); n_fail++;
        end
        n_checks++;
        if ({threshold, desired_bg_r, desired_bg_g, desired_bg_b} !== {thr, br, bgc, bb}) begin
            $display("FAIL frame_config: got %h expected %h", {threshold, desired_bg_r, desired_bg_g, desired_bg_b}, {thr, br, bgc, bb}); n_fail++;
        end
        red_sum_bus = rbus; green_sum_bus = gbus; blue_sum_bus = bbus;
        step(3);
        pe_qsd = 4'b1111;
        step(1);
        n_checks++;
        if ({st, red_exp, green_exp, blue_exp} !== {ST_ACC, prev_rgb}) begin
            $display("FAIL acc_enter: got %b/%h expected %b/%h", st, {red_exp, green_exp, blue_exp}, ST_ACC, prev_rgb); n_fail++;
        end
        step(NUM_PE - 1);
        n_checks++;
        if ({st, pe_ack, red_exp, green_exp, blue_exp} !== {ST_ACC, 1'b0, prev_rgb}) begin
            $display("FAIL acc_last: got %b/%b/%h expected %b/0/%h", st, pe_ack, {red_exp, green_exp, blue_exp}, ST_ACC, prev_rgb); n_fail++;
        end
        step(1);
        n_checks++;
        if ({st, pe_ack} !== {ST_BGR, 1'b1}) begin
            $display("FAIL bgr_pulse: got %b/%b expected %b/1", st, pe_ack, ST_BGR); n_fail++;
        end
        n_checks++;
        if ({red_exp, green_exp, blue_exp} !== exp_rgb) begin
            $display("FAIL exp_colour: got %h expected %h", {red_exp, green_exp, blue_exp}, exp_rgb); n_fail++;
        end
        pe_qsd = 4'b0000;
        step(1);
        n_checks++;
        if ({st, start_bgremoval, pe_ack} !== {ST_BGW, 2'b10}) begin
            $display("FAIL bgw_pulse: got %b/%b%b expected %b/10", st, start_bgremoval, pe_ack, ST_BGW); n_fail++;
        end
        pe_qbgd = 4'b1111;
        step(1);
        n_checks++;
        if ({st, start_bgremoval} !== {ST_BGW, 1'b0}) begin
            $display("FAIL bgw_first_gate: got %b/%b expected %b/0", st, start_bgremoval, ST_BGW); n_fail++;
        end
        step(2);
        n_checks++;
        if ({st, done, pe_ack} !== {ST_DONE, 2'b10}) begin
            $display("FAIL done_hold: got %b/%b%b expected %b/10", st, done, pe_ack, ST_DONE); n_fail++;
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        pe_qbgd = 4'b0000;
        n_checks++;
        if ({st, pe_ack, start_sum, done} !== {ST_INIT, 3'b100}) begin
            $display("FAIL ack_release: got %b/%b%b%b expected %b/100", st, pe_ack, start_sum, done, ST_INIT); n_fail++;
        end
        step(1);
        n_checks++;
        if ({st, pe_ack, red_exp, green_exp, blue_exp} !== {ST_INIT, 1'b0, exp_rgb}) begin
            $display("FAIL init_hold: got %b/%b/%h expected %b/0/%h", st, pe_ack, {red_exp, green_exp, blue_exp}, ST_INIT, exp_rgb); n_fail++;
        end
    endtask

    task automatic test_average();
        do_frame(8'd30, 8'd10, 8'd10, 8'd10, {4{8'd61}}, {4{8'd133}}, {4{8'd198}},
                 {8'd61, 8'd133, 8'd198}, 24'h0);
    endtask

    task automatic test_floor_and_max();
        // red 10+20+30+41=101 -> 25, green 4*255 -> 255, blue 0+1+2+3=6 -> 1
        do_frame(8'd40, 8'd1, 8'd2, 8'd3, {8'd41, 8'd30, 8'd20, 8'd10}, {4{8'd255}}, {8'd3, 8'd2, 8'd1, 8'd0},
                 {8'd25, 8'd255, 8'd1}, {8'd61, 8'd133, 8'd198});
    endtask

    task automatic test_partial_and_reset_mid_acc();
        threshold_in = 8'd7; desired_bg_r_in = 8'd8; desired_bg_g_in = 8'd9; desired_bg_b_in = 8'd11;
        red_sum_bus = {4{8'd100}}; green_sum_bus = {4{8'd100}}; blue_sum_bus = {4{8'd100}};
        start = 1'b1;
        step(1);
        start = 1'b0;
        pe_qsd = 4'b0111;
        for (int i = 0; i < 20; i++) begin
            step(1);
            n_checks++;
            if (st !== ST_SUM) begin
                $display("FAIL partial_qsd_wait: cycle %0d got %b expected %b", i, st, ST_SUM); n_fail++;
            end
        end
        pe_qsd = 4'b1111;
        step(1);
        n_checks++;
        if (st !== ST_ACC) begin
            $display("FAIL partial_qsd_enter: got %b expected %b", st, ST_ACC); n_fail++;
        end
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        pe_qsd = 4'b0000;
        n_checks++;
        if ({st, pe_ack, start_bgremoval} !== {ST_INIT, 2'b00}) begin
            $display("FAIL reset_mid_acc_state: got %b/%b%b expected %b/00", st, pe_ack, start_bgremoval, ST_INIT); n_fail++;
        end
        n_checks++;
        if ({red_exp, green_exp, blue_exp, threshold} !== 32'h0) begin
            $display("FAIL reset_mid_acc_regs: got %h expected 0", {red_exp, green_exp, blue_exp, threshold}); n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_checks++;
            if ({st, pe_ack, start_bgremoval, start_sum} !== {ST_INIT, 3'b000}) begin
                $display("FAIL reset_mid_acc_quiet: got %b/%b%b%b expected %b/000", st, pe_ack, start_bgremoval, start_sum, ST_INIT); n_fail++;
            end
        end
    endtask

    task automatic test_handshake();
        threshold_in = 8'd50; desired_bg_r_in = 8'd1; desired_bg_g_in = 8'd2; desired_bg_b_in = 8'd3;
        red_sum_bus = {4{8'd4}}; green_sum_bus = {4{8'd4}}; blue_sum_bus = {4{8'd4}};
        start = 1'b1;
        step(1);
        start = 1'b0;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        n_checks++;
        if (st !== ST_SUM) begin
            $display("FAIL ack_in_sum: got %b expected %b", st, ST_SUM); n_fail++;
        end
        pe_qsd = 4'b1111;
        step(1 + NUM_PE);
        pe_qsd = 4'b0000;
        n_checks++;
        if ({st, red_exp} !== {ST_BGR, 8'd4}) begin
            $display("FAIL hs_bgr: got %b/%0d expected %b/4", st, red_exp, ST_BGR); n_fail++;
        end
        step(1);
        threshold_in = 8'd99;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_checks++;
        if ({st, start_sum, threshold} !== {ST_BGW, 1'b0, 8'd50}) begin
            $display("FAIL start_in_bgw: got %b/%b/%0d expected %b/0/50", st, start_sum, threshold, ST_BGW); n_fail++;
        end
        pe_qbgd = 4'b1111;
        step(1);
        n_checks++;
        if (st !== ST_DONE) begin
            $display("FAIL hs_done: got %b expected %b", st, ST_DONE); n_fail++;
        end
        start = 1'b1;
        ack = 1'b1;
        step(1);
        start = 1'b0;
        ack = 1'b0;
        pe_qbgd = 4'b0000;
        n_checks++;
        if ({st, pe_ack, start_sum} !== {ST_INIT, 2'b10}) begin
            $display("FAIL start_ack_done: got %b/%b%b expected %b/10", st, pe_ack, start_sum, ST_INIT); n_fail++;
        end
        step(1);
        n_checks++;
        if ({st, pe_ack, start_sum, threshold} !== {ST_INIT, 2'b00, 8'd50}) begin
            $display("FAIL start_dropped: got %b/%b%b/%0d expected %b/00/50", st, pe_ack, start_sum, threshold, ST_INIT); n_fail++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ack = 1'b0;
        threshold_in = '0; desired_bg_r_in = '0; desired_bg_g_in = '0; desired_bg_b_in = '0;
        red_sum_bus = '0; green_sum_bus = '0; blue_sum_bus = '0;
        pe_qsd = '0; pe_qbgd = '0;
        #2;
        test_reset();
        test_average();
        test_floor_and_max();
        test_partial_and_reset_mid_acc();
        test_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
